uart_instr_loader: RTL and testbench
====================================

// Module: uart_instr_loader
// PURPOSE
//  Producer end of the core's instruction-queue interface (empty/re).
//  Accepts a stream of UART bytes and assembles them into INSTR_W-bit instruction words.
//  Buffers the words in a DEPTH-entry FIFO.
//  Presents the words to the fetch side, which pops with re when !empty && !freeze.
//  Replaces the hard-coded instruction source so programs can be loaded over UART at run time.
// PARAMETERS
//  INSTR_W      16     instruction word width; must be a multiple of 8 (NBYTES = INSTR_W/8)
//  DEPTH        16     FIFO entries; power of 2, >= 2
//  TIMEOUT_CYC  50000  idle cycles after which a partial word is discarded; must be >= 1
// PORTS
//  clk         in   1                  system clock; all state on posedge
//  reset       in   1                  synchronous, active-high; clears all state
//  flush       in   1                  synchronous clear of FIFO + assembler (same effect as reset)
//  rx_data     in   8                  received UART byte
//  rx_valid    in   1                  rx_data valid this cycle
//  rx_ready    out  1                  loader accepts byte this cycle
//  re          in   1                  pop request from fetch side
//  empty       out  1                  FIFO holds no complete words
//  full        out  1                  FIFO holds DEPTH words
//  count       out  $clog2(DEPTH)+1    words currently stored
//  dout        out  INSTR_W            popped instruction word
//  dout_valid  out  1                  dout holds a newly popped word (1-cycle pulse)
//  resync      out  1                  1-cycle pulse: partial word discarded by timeout
// BEHAVIOUR
//  Reset / flush
//   - Outputs after reset: rx_ready=1, empty=1, full=0, count=0, dout=0, dout_valid=0, resync=0.
//   - flush has the same effect as reset. A partial word is dropped; in-flight words are dropped.
//   - reset or flush has priority over every other event in the same cycle.
//  Assembler
//   - byte_idx counts 0..NBYTES-1. The first byte received goes to bits [7:0] (little-endian).
//   - Byte accepted = rx_valid && rx_ready. On acceptance byte_idx increments; the idle timer clears.
//   - When byte_idx==NBYTES-1 and a byte is accepted, the full word is pushed and byte_idx returns to 0.
//   - rx_ready = (byte_idx != NBYTES-1) || !full. Non-final bytes are always accepted.
//   - rx_ready is combinational from registered state only. It has no path from rx_valid or re.
//  Idle timeout
//   - While byte_idx != 0 and no byte is accepted, the timer increments.
//   - When the timer reaches TIMEOUT_CYC: byte_idx resets to 0, the timer clears, and resync pulses for 1 cycle.
//   - The timer is held at 0 while byte_idx==0.
//  FIFO
//   - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
//   - empty = (wptr==rptr). full = (address bits equal && wrap bits differ). count = wptr - rptr.
//   - A pop occurs when re && !empty at the clock edge. Pop latency is 1:
//     - dout takes the mem[rptr] value at the next edge.
//     - dout_valid=1 for exactly that cycle.
//   - re while empty is ignored: dout holds its value, dout_valid=0.
//   - dout holds the last popped word until the next pop.
//   - Push and pop in the same cycle:
//     - Not empty: both occur, count unchanged.
//     - Empty: only the push occurs; the word is poppable the next cycle.
//     - Full: only the pop occurs. No push is possible, because rx_ready was 0.
//   - Pointers wrap naturally modulo 2*DEPTH. No word is lost or duplicated across the wrap.
// TESTING
//  1. Reset, then bytes 0x34,0x12 on consecutive cycles -> empty=0, count=1 the next cycle.
//     Then re=1 -> dout=0x1234 with dout_valid=1 one cycle later; empty=1.
//  2. Push 16 words 0x0000..0x000F with no pops -> full=1, count=16.
//     A further final byte is refused (rx_ready=0). One pop returns 0x0000, and rx_ready returns to 1.
//  3. Push 40 words while popping each as it arrives (forces pointer wrap)
//     -> dout sequence exactly 0..39, no drops, no duplicates.
//  4. Send a single byte 0xAA, then idle for TIMEOUT_CYC cycles -> resync pulses once.
//     Then 0x78,0x56 -> popped word is 0x5678.
//  5. re held high while empty for 10 cycles -> dout_valid stays 0 and dout is unchanged.
//  6. Load 5 words plus 1 byte, then assert flush for 1 cycle
//     -> empty=1, count=0, and the next 2 bytes form a fresh word.

Source files
------------

// File: rtl/uart_instr_loader.sv
// UART-to-instruction-queue loader: assembles little-endian bytes into INSTR_W-bit
// words and buffers them in a FIFO popped by the fetch side with re.
module uart_instr_loader #(
    parameter int INSTR_W     = 16,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   re,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [INSTR_W-1:0]     dout,
    output logic                   dout_valid,
    output logic                   resync
);
    localparam int NBYTES = INSTR_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] LAST_IDX  = BW'(NBYTES - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW:0]        wptr;
    logic [AW:0]        rptr;
    logic [BW-1:0]      byte_idx;
    logic [TW-1:0]      idle_timer;
    logic [INSTR_W-1:0] asm_word;
    logic [INSTR_W-1:0] asm_next;
    logic               last_byte;
    logic               accept;
    logic               push;
    logic               pop;

    // rx_ready depends on registered state only, so no rx_valid/re -> rx_ready path exists
    assign last_byte = (byte_idx == LAST_IDX);
    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count     = wptr - rptr;
    assign rx_ready  = !last_byte || !full;
    assign accept    = rx_valid && rx_ready;
    assign push      = accept && last_byte;
    assign pop       = re && !empty;

    always_comb begin
        asm_next = asm_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_idx == BW'(i)) begin
                asm_next[i*8 +: 8] = rx_data;
            end
        end
    end

    // Data storage: every byte lane is rewritten before a push, so no clear is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            asm_word <= asm_next;
        end
        if (push) begin
            mem[wptr[AW-1:0]] <= asm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr       <= '0;
            rptr       <= '0;
            byte_idx   <= '0;
            idle_timer <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            resync     <= 1'b0;
        end else begin
            dout_valid <= pop;
            resync     <= 1'b0;
            if (pop) begin
                dout <= mem[rptr[AW-1:0]];
                rptr <= rptr + 1'b1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (accept) begin
                byte_idx   <= last_byte ? '0 : byte_idx + 1'b1;
                idle_timer <= '0;
            end else if (byte_idx != '0) begin
                if (idle_timer == TIMER_MAX) begin
                    byte_idx   <= '0;
                    idle_timer <= '0;
                    resync     <= 1'b1;
                end else begin
                    idle_timer <= idle_timer + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_instr_loader.sv
// Bench for uart_instr_loader: table-driven first transaction, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_uart_instr_loader;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 16;
    localparam int TO      = 64;
    localparam int NB      = INSTR_W / 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               re;
    logic               empty;
    logic               full;
    logic [CW-1:0]      count;
    logic [INSTR_W-1:0] dout;
    logic               dout_valid;
    logic               resync;

    int nvec = 0;
    int nmis = 0;

    uart_instr_loader #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .re(re), .empty(empty), .full(full), .count(count),
        .dout(dout), .dout_valid(dout_valid), .resync(resync)
    );

    always #5 clk = ~clk;

    // Reference model: stored words, bytes of the word in progress, idle cycle count
    logic [INSTR_W-1:0] mq[$];
    logic [7:0]         mparts[$];
    int                 midle;
    logic [INSTR_W-1:0] mdout;
    bit                 mdv;
    bit                 mrs;

    function automatic void m_reset();
        mq.delete();
        mparts.delete();
        midle = 0;
        mdout = '0;
        mdv   = 1'b0;
        mrs   = 1'b0;
    endfunction

    function automatic bit m_ready();
        return (mparts.size() != NB - 1) || (mq.size() != DEPTH);
    endfunction

    function automatic void m_clock(bit v, logic [7:0] d, bit r, bit f);
        bit acc;
        logic [INSTR_W-1:0] w;
        if (f) begin
            m_reset();
            return;
        end
        acc = v && m_ready();
        mdv = r && (mq.size() != 0);
        mrs = 1'b0;
        if (mdv) mdout = mq.pop_front();
        if (acc) begin
            mparts.push_back(d);
            midle = 0;
            if (mparts.size() == NB) begin
                w = '0;
                foreach (mparts[i]) w[i*8 +: 8] = mparts[i];
                mq.push_back(w);
                mparts.delete();
            end
        end else if (mparts.size() != 0) begin
            midle++;
            if (midle == TO) begin
                mparts.delete();
                midle = 0;
                mrs   = 1'b1;
            end
        end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_rx_ready", 32'(rx_ready), 32'(m_ready()));
        chk("m_empty", 32'(empty), 32'(mq.size() == 0));
        chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_dout", 32'(dout), 32'(mdout));
        chk("m_dout_valid", 32'(dout_valid), 32'(mdv));
        chk("m_resync", 32'(resync), 32'(mrs));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge
    task automatic cyc(bit v, logic [7:0] d, bit r, bit f);
        rx_valid = v;
        rx_data  = d;
        re       = r;
        flush    = f;
        m_clock(v, d, r, f);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          r;
        bit          e_empty;
        int          e_count;
        logic [15:0] e_dout;
        bit          e_dv;
    } vec_t;

    vec_t tbl[4];
    logic [INSTR_W-1:0] got[$];

    initial begin
        int pulses;
        int at;
        int pv;
        int pr;

        tbl[0] = '{v: 1'b1, d: 8'h34, r: 1'b0, e_empty: 1'b1, e_count: 0, e_dout: 16'h0000, e_dv: 1'b0};
        tbl[1] = '{v: 1'b1, d: 8'h12, r: 1'b0, e_empty: 1'b0, e_count: 1, e_dout: 16'h0000, e_dv: 1'b0};
        tbl[2] = '{v: 1'b0, d: 8'h00, r: 1'b1, e_empty: 1'b1, e_count: 0, e_dout: 16'h1234, e_dv: 1'b1};
        tbl[3] = '{v: 1'b0, d: 8'h00, r: 1'b0, e_empty: 1'b1, e_count: 0, e_dout: 16'h1234, e_dv: 1'b0};

        reset = 1'b1; flush = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; re = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_resync", 32'(resync), 32'd0);

        // First word assembled little-endian and popped
        for (int i = 0; i < 4; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk("t1_empty", 32'(empty), 32'(tbl[i].e_empty));
            chk("t1_count", 32'(count), 32'(tbl[i].e_count));
            chk("t1_dout", 32'(dout), 32'(tbl[i].e_dout));
            chk("t1_dout_valid", 32'(dout_valid), 32'(tbl[i].e_dv));
        end

        // Fill to full, final byte refused, one pop reopens
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            cyc(1'b1, 8'h00, 1'b0, 1'b0);
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        chk("t2_ready_low", 32'(rx_ready), 32'd0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("t2_refused_count", 32'(count), 32'd16);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_pop_dout", 32'(dout), 32'h0000);
        chk("t2_pop_valid", 32'(dout_valid), 32'd1);
        chk("t2_ready_back", 32'(rx_ready), 32'd1);
        chk("t2_count_15", 32'(count), 32'd15);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("t2_refill_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t2_drain_dout", 32'(dout), 32'(i + 1));
            chk("t2_drain_valid", 32'(dout_valid), 32'd1);
        end
        chk("t2_drained_empty", 32'(empty), 32'd1);

        // Streaming push/pop across the pointer wrap
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            if (dout_valid) got.push_back(dout);
            cyc(1'b1, 8'h00, 1'b0, 1'b0);
            if (dout_valid) got.push_back(dout);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        if (dout_valid) got.push_back(dout);
        chk("t3_len", 32'(got.size()), 32'd40);
        foreach (got[k]) chk("t3_word", 32'(got[k]), 32'(k));

        // Partial word discarded after TO idle cycles
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        pulses = 0;
        at = -1;
        for (int k = 1; k <= TO + 5; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            if (resync) begin
                pulses++;
                if (at < 0) at = k;
            end
        end
        chk("t4_pulses", 32'(pulses), 32'd1);
        chk("t4_pulse_at", 32'(at), 32'(TO));
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        cyc(1'b1, 8'h56, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_word", 32'(dout), 32'h5678);
        chk("t4_valid", 32'(dout_valid), 32'd1);

        // re held while empty
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t5_valid", 32'(dout_valid), 32'd0);
            chk("t5_dout", 32'(dout), 32'h5678);
        end

        // Flush drops stored words and the partial word, with priority over rx/re
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            cyc(1'b1, 8'h00, 1'b0, 1'b0);
        end
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        chk("t6_count5", 32'(count), 32'd5);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(dout_valid), 32'd0);
        cyc(1'b1, 8'hCD, 1'b0, 1'b0);
        cyc(1'b1, 8'hAB, 1'b0, 1'b0);
        chk("t6_count1", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_word", 32'(dout), 32'hABCD);

        // Randomized traffic in phases of differing byte and pop density
        for (int n = 0; n < 4000; n++) begin
            case ((n / 500) % 4)
                0: begin pv = 85; pr = 20; end
                1: begin pv = 40; pr = 60; end
                2: begin pv = 10; pr = 90; end
                default: begin pv = 1; pr = 30; end
            endcase
            cyc($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < pr,
                $urandom_range(299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
